spi_master_ctrl: RTL

- Master-side sequencer for the 12-bit SPI slave datapath.
- Generates SCLK, drives MOSI MSB-first and frames each transfer with a terminating LOAD edge; the slave latches its received word and reloads its transmit register on that edge.
- Captures MISO into a parallel receive word.
- Sits between system logic (start/data/done handshake) and the slave's serial pins.

---
 rtl/spi_master_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer for the m-bit slave datapath.
// Each frame has m data SCLK edges followed by one load edge. On the load edge LOAD=1 and MOSI=0.
// MISO is shifted in just before edges 2..m+1. SCLK is a dedicated flop, so it is glitch-free.
module spi_master_ctrl #(
  parameter int unsigned m   = 12,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         st,
  input  logic [m-1:0] MTX_DAT,
  output logic [m-1:0] MRX_DAT,
  output logic         SCLK,
  output logic         MOSI,
  output logic         LOAD,
  input  logic         MISO,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(m + 1);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BitLast = CW'(m);
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StFin} state_e;

  state_e        r_state;
  logic [m-1:0]  r_tx_sr;
  logic [m-1:0]  r_rx_sr;
  logic [m-1:0]  r_mrx;
  logic [CW-1:0] r_bit_cnt;
  logic [DW-1:0] r_div_cnt;
  logic          r_sclk;
  logic          r_load;
  logic          r_busy;
  logic          r_done;
  logic          w_half_end;

  assign w_half_end = (r_div_cnt == DivLast);

  // The TX shifter holds only zeros outside the data edges, so its MSB is MOSI directly.
  // This covers idle, the load edge, FIN, and the period after a reset.
  assign MOSI    = r_tx_sr[m-1];
  assign SCLK    = r_sclk;
  assign LOAD    = r_load;
  assign busy    = r_busy;
  assign done    = r_done;
  assign MRX_DAT = r_mrx;

  // Frame sequencer: all state and registered pin outputs advance together.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= StIdle;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_mrx     <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (st) begin
            r_tx_sr   <= MTX_DAT;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= StLow;
          end
        end
        StLow: begin
          if (w_half_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
            // The first edge has no preceding MISO bit of interest.
            if (r_bit_cnt != '0) begin
              r_rx_sr <= {r_rx_sr[m-2:0], MISO};
            end
            r_state <= StHigh;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        StHigh: begin
          if (w_half_end) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            if (r_bit_cnt == BitLast) begin
              r_load  <= 1'b0;
              r_state <= StFin;
            end else begin
              r_tx_sr   <= {r_tx_sr[m-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              // Raise LOAD for the low phase that precedes the load edge.
              r_load    <= (r_bit_cnt == (BitLast - 1'b1));
              r_state   <= StLow;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        StFin: begin
          r_mrx   <= r_rx_sr;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
